// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and datapath width.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decodes the operation code and flags unsupported codes.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_c,
    output logic             illegal_c
);

    logic slt_c;

    assign slt_c = ($signed(src_a) < $signed(src_b));

    // Operation select; unsupported codes produce a zero result and raise the flag.
    always_comb begin
        result_c  = '0;
        illegal_c = 1'b0;
        case (alu_control)
            ALU_ADD: result_c = src_a + src_b;
            ALU_SUB: result_c = src_a - src_b;
            ALU_AND: result_c = src_a & src_b;
            ALU_OR:  result_c = src_a | src_b;
            ALU_SLT: result_c = {{(WIDTH-1){1'b0}}, slt_c};
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a 2-entry in-order result buffer.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal_op
);

    localparam int unsigned DEPTH = 2;

    logic [WIDTH-1:0] core_result_c;
    logic             core_illegal_c;

    logic [WIDTH-1:0] res_q [DEPTH];
    logic             ill_q [DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push_c;
    logic             pop_c;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result_c    (core_result_c),
        .illegal_c   (core_illegal_c)
    );

    // Handshake flags depend only on registered occupancy.
    assign in_ready  = (count_q < 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign push_c    = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;

    // Head entry drives the outputs; zero is gated so an empty stage reports 0.
    assign alu_result = res_q[rd_ptr_q];
    assign illegal_op = ill_q[rd_ptr_q];
    assign zero       = out_valid && (res_q[rd_ptr_q] == '0);

    // Next occupancy from push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Buffer storage, pointers and occupancy; reset flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                res_q[i] <= '0;
                ill_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_c) begin
                res_q[wr_ptr_q] <= core_result_c;
                ill_q[wr_ptr_q] <= core_illegal_c;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero;
    logic        illegal_op;

    int n_checks;
    int n_pass;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
    endtask

    // One accepted op with out_ready held high; outputs checked after the edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        present(op, a, b);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        alu_control = ALU_ADD;
        src_a       = 32'd1;
        src_b       = 32'd1;

        // Reset held two cycles with in_valid high
        step();
        step();
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_result",    alu_result,      32'd0);
        check("rst_zero",      32'(zero),       32'd0);
        check("rst_illegal",   32'(illegal_op), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst_nothing_buffered", 32'(out_valid), 32'd0);

        // Basic ops, one cycle latency
        out_ready = 1'b1;
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        check("add_valid",  32'(out_valid), 32'd1);
        check("add_result", alu_result,     32'h0000_0000);
        check("add_zero",   32'(zero),      32'd1);
        issue(ALU_SUB, 32'd5, 32'd7);
        check("sub_result", alu_result,     32'hFFFF_FFFE);
        check("sub_zero",   32'(zero),      32'd0);
        issue(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        check("and_result", alu_result,     32'h0000_F000);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg_lt_pos", alu_result, 32'd1);
        issue(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos_lt_neg", alu_result, 32'd0);
        issue(ALU_SLT, 32'h8000_0000, 32'h8000_0000);
        check("slt_equal",      alu_result, 32'd0);
        check("slt_equal_zero", 32'(zero),  32'd1);
        step();
        check("drain_empty", 32'(out_valid), 32'd0);

        // Backpressure: three ops offered while the consumer stalls
        out_ready = 1'b0;
        present(ALU_ADD, 32'd1, 32'd2);
        step();
        check("bp_ready_after_1", 32'(in_ready), 32'd1);
        check("bp_head_1",        alu_result,    32'd3);
        present(ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        step();
        check("bp_ready_after_2", 32'(in_ready),  32'd0);
        check("bp_valid_full",    32'(out_valid), 32'd1);
        present(ALU_SUB, 32'd9, 32'd4);
        step();
        step();
        check("bp_held_ready", 32'(in_ready), 32'd0);
        check("bp_held_head",  alu_result,    32'd3);
        out_ready = 1'b1;
        step();
        check("bp_out_2",        alu_result,    32'h0000_00FF);
        check("bp_ready_freed",  32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_out_3",       alu_result,     32'd5);
        check("bp_out_3_valid", 32'(out_valid), 32'd1);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Illegal code, then a legal op clears the flag
        issue(3'b110, 32'd7, 32'd3);
        check("ill_result", alu_result,      32'd0);
        check("ill_flag",   32'(illegal_op), 32'd1);
        check("ill_zero",   32'(zero),       32'd1);
        issue(ALU_ADD, 32'd2, 32'd3);
        check("post_ill_result", alu_result,      32'd5);
        check("post_ill_flag",   32'(illegal_op), 32'd0);
        step();

        // Reset mid-operation with two entries buffered
        out_ready = 1'b0;
        present(ALU_ADD, 32'd10, 32'd0);
        step();
        present(ALU_ADD, 32'd11, 32'd0);
        step();
        in_valid = 1'b0;
        check("mid_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_in_ready",  32'(in_ready),  32'd1);
        check("mid_result",    alu_result,     32'd0);
        out_ready = 1'b1;
        step();
        check("mid_no_stale", 32'(out_valid), 32'd0);
        issue(ALU_ADD, 32'd4, 32'd4);
        check("mid_after_op", alu_result, 32'd8);
        step();
        check("mid_final_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that consumes the 3-bit `ALUControl` code produced by the control unit's ALU decoder and returns the result of the selected ALU operation. It has valid/ready handshakes on both sides and a 2-entry in-order output buffer, so a stalled downstream (memory or writeback) does not lose results. It sits between decode/control and the memory/writeback stage of the RISC-V core, and supplies `zero` for branch resolution.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  the stage can accept an operation this cycle.
- `alu_control`  in  3  operation code (encoding in Operation).
- `src_a`  in  WIDTH  operand A.
- `src_b`  in  WIDTH  operand B.
- `out_valid`  out  1  the head result is valid.
- `out_ready`  in  1  the consumer takes the head result this cycle.
- `alu_result`  out  WIDTH  head result.
- `zero`  out  1  head result equals 0.
- `illegal_op`  out  1  head entry came from an unsupported code.

## Operation
- Code encoding:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 101 SLT: signed A<B, giving 1 or 0, zero-extended to WIDTH.
- ADD and SUB wrap modulo 2^WIDTH. No overflow or carry output.
- Codes 100, 110 and 111 are illegal. For these, the result is 0 and `illegal_op` is 1.
- `zero` is computed from the stored result, so an illegal op reports `zero`=1.
- Accept when `in_valid && in_ready`. The computed result is written into the buffer on that clock edge.
- Buffer: 2-entry FIFO, strictly in order, tracked by `count` (0..2).
- `in_ready` = (`count` < 2). It depends only on registered state, never on `out_ready` (no combinational ready path).
- `out_valid` = (`count` > 0). The outputs always show the head entry.
- Pop when `out_valid && out_ready`.
- Count updates:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle (only possible at count 1): count stays 1. The new entry becomes head on the next cycle.
- At count 2, `in_valid` is ignored until a pop occurs. The pop frees `in_ready` in the following cycle.
- Inputs are don't-care when `in_valid`=0. Output data is held stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: an op accepted at edge N is visible on the outputs after edge N, when the buffer is empty or being drained.
- Throughput is one op per cycle when `out_ready` is held at 1.
- Reset (synchronous, applied on any edge with `rst`=1):
  - `count`=0, `out_valid`=0, `in_ready`=1.
  - `alu_result`=0, `zero`=0, `illegal_op`=0. Output data fields are cleared, not left X.
- Reset mid-operation discards all buffered entries. An accept that coincides with reset is dropped.
- In-flight results are never reordered or duplicated.

## Structure
- Shared package `alu_pkg` holds:
  - typedef enum logic [2:0] `alu_op_e` (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
  - `ALU_W`=32.
- The ALU decoder and this stage both import `alu_pkg`, so the code encoding has a single source.
- Sub-module `alu_core`: purely combinational; `alu_control`, A and B in; result and illegal flag out.
- `alu_exec_stage` holds the 2-entry buffer, pointers and count around `alu_core`.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid`=1 -> `in_ready`=1, `out_valid`=0, `alu_result`=0; nothing is buffered.
- Basic ops, `out_ready`=1:
  - ADD 0xFFFFFFFF+1 -> 0x00000000, `zero`=1, one cycle later.
  - SUB 5−7 -> 0xFFFFFFFE, `zero`=0.
  - AND 0xF0F0&0xFF00 -> 0xF000.
- SLT signedness:
  - A=0xFFFFFFFF, B=1 -> 1.
  - A=1, B=0xFFFFFFFF -> 0.
  - A=B=0x80000000 -> 0, `zero`=1.
- Backpressure, `out_ready`=0: offer ADD 1+2, then OR 0xF0|0x0F, then SUB 9−4.
  - `in_ready` drops after the 2nd accept; the 3rd op is held.
  - With `out_ready`=1, outputs are 3, 0xFF, then 5, in order.
- Illegal code 3'b110 with A=7, B=3 -> `alu_result`=0, `illegal_op`=1, `zero`=1. The next legal op has `illegal_op`=0.
- Reset mid-operation: with 2 entries buffered, assert `rst` for 1 cycle -> next cycle `out_valid`=0, `in_ready`=1, and no stale result reappears.
